// File: rtl/uxa_ps2_rxq_if.sv
// Bundle between the PS/2 receive queue and its neighbours: the shifter
// (d_i/frame_i/shf_reset_o), the raw PS/2 clock and the CPU pop/status side.
interface uxa_ps2_rxq_if;
   logic [7:0] d_i;
   logic       frame_i;
   logic       ps2_c_i;
   logic       shf_reset_o;
   logic [7:0] q_o;
   logic       valid_o;
   logic       read_i;
   logic       full_o;
   logic       overflow_o;
   logic       clr_ovf_i;

   modport slave (
      input  d_i, frame_i, ps2_c_i, read_i, clr_ovf_i,
      output shf_reset_o, q_o, valid_o, full_o, overflow_o
   );

   modport master (
      output d_i, frame_i, ps2_c_i, read_i, clr_ovf_i,
      input  shf_reset_o, q_o, valid_o, full_o, overflow_o
   );
endinterface

// File: rtl/uxa_ps2_rxq.sv
// PS/2 receive controller: captures completed shifter frames into a FWFT FIFO,
// re-arms the shifter after each capture and after a stalled partial frame.
module uxa_ps2_rxq #(
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned TIMEOUT = 25000
) (
   input  logic          sys_clk_i,
   input  logic          reset_i,
   uxa_ps2_rxq_if.slave  bus
);
   localparam int unsigned     AW       = $clog2(DEPTH);
   localparam int unsigned     CW       = $clog2(TIMEOUT + 1);
   localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [CW-1:0]   TO_CNT   = CW'(TIMEOUT);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_CLEAR    = 2'd1;
   localparam logic [1:0] ST_WAIT_LOW = 2'd2;

   logic [1:0]    state;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          overflow;

   logic          c_s1;
   logic          c_s2;
   logic          c_prev;
   logic [CW-1:0] wd_cnt;
   logic          wd_armed;

   logic          is_full;
   logic          is_empty;
   logic          capture;
   logic          pop;
   logic          push;
   logic          drop;
   logic          c_edge;
   logic          wd_fire;

   always_comb begin
      is_full  = (count == FULL_CNT);
      is_empty = (count == '0);
      capture  = (state == ST_IDLE) && bus.frame_i;
      pop      = bus.read_i && !is_empty;
      // a pop in the same cycle frees the slot, so a full FIFO still accepts
      push     = capture && (!is_full || pop);
      drop     = capture && is_full && !pop;
      c_edge   = c_s2 ^ c_prev;
      // a pending frame takes precedence; its capture issues the only pulse
      wd_fire  = wd_armed && (wd_cnt == TO_CNT) && (state == ST_IDLE) && !bus.frame_i;
   end

   always_ff @(posedge sys_clk_i or posedge reset_i) begin
      if (reset_i) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:     if (bus.frame_i)  state <= ST_CLEAR;
            ST_CLEAR:                      state <= ST_WAIT_LOW;
            ST_WAIT_LOW: if (!bus.frame_i) state <= ST_IDLE;
            default:                       state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge sys_clk_i) begin
      if (push) mem[wr_ptr] <= bus.d_i;
   end

   always_ff @(posedge sys_clk_i or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
         if (drop)               overflow <= 1'b1;
         else if (bus.clr_ovf_i) overflow <= 1'b0;
      end
   end

   // the counter saturates, so the armed flag limits the pulse to once per quiet period
   always_ff @(posedge sys_clk_i or posedge reset_i) begin
      if (reset_i) begin
         c_s1     <= 1'b1;
         c_s2     <= 1'b1;
         c_prev   <= 1'b1;
         wd_cnt   <= '0;
         wd_armed <= 1'b1;
      end else begin
         c_s1   <= bus.ps2_c_i;
         c_s2   <= c_s1;
         c_prev <= c_s2;
         if (c_edge) begin
            wd_cnt   <= '0;
            wd_armed <= 1'b1;
         end else begin
            if (wd_cnt != TO_CNT) wd_cnt <= wd_cnt + CW'(1);
            else                  wd_armed <= 1'b0;
         end
      end
   end

   assign bus.shf_reset_o = (state == ST_CLEAR) || wd_fire;
   assign bus.q_o         = is_empty ? '0 : mem[rd_ptr];
   assign bus.valid_o     = !is_empty;
   assign bus.full_o      = is_full;
   assign bus.overflow_o  = overflow;
endmodule

// File: tb/tb_uxa_ps2_rxq.sv
// Scoreboard bench for uxa_ps2_rxq: stimulus logs accepted bytes, a negedge
// monitor compares the FIFO outputs and pops on reads.
module tb_uxa_ps2_rxq;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned TO_A  = 200;
   localparam int unsigned TO_B  = 8;
   localparam int          SBN   = 4096;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uxa_ps2_rxq_if bus_a ();
   uxa_ps2_rxq_if bus_b ();

   uxa_ps2_rxq #(.DEPTH(DEPTH), .TIMEOUT(TO_A)) dut_a (
      .sys_clk_i (clk),
      .reset_i   (rst),
      .bus       (bus_a)
   );

   uxa_ps2_rxq #(.DEPTH(DEPTH), .TIMEOUT(TO_B)) dut_b (
      .sys_clk_i (clk),
      .reset_i   (rst),
      .bus       (bus_b)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // expected byte stream: stimulus appends at wr_i, monitor consumes at rd_i
   logic [7:0] sb_mem [SBN];
   int         wr_i = 0;
   int         rd_i = 0;
   logic       ovf_exp;
   logic       mon_en;

   logic tog_en;
   logic ps2_tog;
   logic ps2_man;
   assign bus_a.ps2_c_i = tog_en ? ps2_tog : ps2_man;

   int pulses_a = 0;
   int pulses_b = 0;
   int last_a   = 0;
   int t0;
   int p0;

   function automatic void check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic int sb_size();
      return wr_i - rd_i;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // keeps the PS/2 clock busy so the watchdog stays quiet during FIFO tests
   initial begin
      ps2_tog = 1'b1;
      forever begin
         repeat ($urandom_range(5, 60)) @(posedge clk);
         #1 ps2_tog = ~ps2_tog;
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         rd_i = wr_i;
      end else if (mon_en) begin
         check("valid", int'(bus_a.valid_o), int'(sb_size() != 0));
         check("full", int'(bus_a.full_o), int'(sb_size() == DEPTH));
         check("overflow", int'(bus_a.overflow_o), int'(ovf_exp));
         check("head_q", int'(bus_a.q_o), (sb_size() != 0) ? int'(sb_mem[rd_i % SBN]) : 0);
         if (bus_a.read_i && sb_size() != 0) rd_i = rd_i + 1;
      end
      if (bus_a.shf_reset_o) begin
         pulses_a = pulses_a + 1;
         last_a   = cyc;
      end
      if (bus_b.shf_reset_o) pulses_b = pulses_b + 1;
   end

   task automatic frame_op(input logic [7:0] b, input logic rd, input logic clr, input int hold);
      int waited;
      @(posedge clk); #1;
      bus_a.d_i       = b;
      bus_a.frame_i   = 1'b1;
      bus_a.read_i    = rd;
      bus_a.clr_ovf_i = clr;
      waited = 0;
      do begin
         @(posedge clk); #1;
         waited++;
      end while (!bus_a.shf_reset_o && waited < 4);
      check("capture_pulse", int'(bus_a.shf_reset_o), 1);
      check("capture_latency", waited, 1);
      if (sb_size() < DEPTH) begin
         sb_mem[wr_i % SBN] = b;
         wr_i = wr_i + 1;
         if (clr) ovf_exp = 1'b0;
      end else begin
         ovf_exp = 1'b1;
      end
      bus_a.read_i    = 1'b0;
      bus_a.clr_ovf_i = 1'b0;
      @(posedge clk); #1;
      check("pulse_width", int'(bus_a.shf_reset_o), 0);
      repeat (hold) begin
         @(posedge clk); #1;
      end
      bus_a.frame_i = 1'b0;
   endtask

   task automatic read_op();
      @(posedge clk); #1;
      bus_a.read_i = 1'b1;
      @(posedge clk); #1;
      bus_a.read_i = 1'b0;
   endtask

   task automatic clr_op();
      @(posedge clk); #1;
      bus_a.clr_ovf_i = 1'b1;
      @(posedge clk); #1;
      bus_a.clr_ovf_i = 1'b0;
      ovf_exp = 1'b0;
   endtask

   task automatic wd_pair();
      @(posedge clk); #1;
      ps2_man = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      ps2_man = 1'b1;
      t0 = cyc;
      p0 = pulses_a;
      repeat (TO_A + 50) @(posedge clk);
      @(negedge clk);
      check("wd_pulse_count", pulses_a - p0, 1);
      check("wd_pulse_delay", int'((last_a - t0 >= int'(TO_A) + 2) && (last_a - t0 <= int'(TO_A) + 4)), 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      rst     = 1'b1;
      mon_en  = 1'b0;
      ovf_exp = 1'b0;
      tog_en  = 1'b0;
      ps2_man = 1'b1;
      bus_a.d_i = '0; bus_a.frame_i = 1'b0; bus_a.read_i = 1'b0; bus_a.clr_ovf_i = 1'b0;
      bus_b.d_i = '0; bus_b.frame_i = 1'b0; bus_b.read_i = 1'b0; bus_b.clr_ovf_i = 1'b0;
      bus_b.ps2_c_i = 1'b1;

      repeat (20) begin
         @(posedge clk); #1;
         bus_a.d_i       = 8'($urandom);
         bus_a.frame_i   = 1'($urandom_range(0, 1));
         bus_a.read_i    = 1'($urandom_range(0, 1));
         bus_a.clr_ovf_i = 1'($urandom_range(0, 1));
         ps2_man         = 1'($urandom_range(0, 1));
         @(negedge clk);
         check("rst_shf", int'(bus_a.shf_reset_o), 0);
         check("rst_valid", int'(bus_a.valid_o), 0);
         check("rst_full", int'(bus_a.full_o), 0);
         check("rst_ovf", int'(bus_a.overflow_o), 0);
         check("rst_q", int'(bus_a.q_o), 0);
      end
      @(posedge clk); #1;
      bus_a.d_i = '0; bus_a.frame_i = 1'b0; bus_a.read_i = 1'b0; bus_a.clr_ovf_i = 1'b0;
      ps2_man = 1'b1;
      rst     = 1'b0;
      mon_en  = 1'b1;
      repeat (10) begin
         @(negedge clk);
         check("idle_shf", int'(bus_a.shf_reset_o), 0);
      end
      tog_en = 1'b1;

      frame_op(8'h64, 1'b0, 1'b0, 0);
      @(negedge clk);
      check("single_q", int'(bus_a.q_o), 8'h64);
      check("single_valid", int'(bus_a.valid_o), 1);
      read_op();
      @(negedge clk);
      check("single_pop_valid", int'(bus_a.valid_o), 0);
      check("single_pop_q", int'(bus_a.q_o), 0);

      for (int i = 0; i < 16; i++) frame_op(8'(i), 1'b0, 1'b0, 0);
      @(negedge clk);
      check("fill_full", int'(bus_a.full_o), 1);
      check("fill_q", int'(bus_a.q_o), 8'h00);
      frame_op(8'hAA, 1'b0, 1'b0, 1);
      @(negedge clk);
      check("ovf_set", int'(bus_a.overflow_o), 1);
      check("ovf_q", int'(bus_a.q_o), 8'h00);
      clr_op();
      @(negedge clk);
      check("ovf_clr", int'(bus_a.overflow_o), 0);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         check("drain_order", int'(bus_a.q_o), i);
         read_op();
      end
      @(negedge clk);
      check("drain_empty", int'(bus_a.valid_o), 0);

      for (int i = 0; i < 16; i++) frame_op(8'(8'h20 + i), 1'b0, 1'b0, 0);
      frame_op(8'h55, 1'b1, 1'b0, 0);
      @(negedge clk);
      check("fullpop_ovf", int'(bus_a.overflow_o), 0);
      check("fullpop_full", int'(bus_a.full_o), 1);
      check("fullpop_q", int'(bus_a.q_o), 8'h21);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (i == 15) check("fullpop_last", int'(bus_a.q_o), 8'h55);
         read_op();
      end

      for (int k = 0; k < 300; k++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: frame_op(8'($urandom), 1'($urandom_range(0, 1)),
                                 1'($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)));
            4, 5, 6, 7: read_op();
            8:          clr_op();
            default:    repeat ($urandom_range(1, 4)) @(posedge clk);
         endcase
      end
      repeat (DEPTH) read_op();
      clr_op();
      @(negedge clk);
      check("random_drained", int'(bus_a.valid_o), 0);

      tog_en  = 1'b0;
      ps2_man = 1'b1;
      repeat (3) @(posedge clk);
      wd_pair();
      wd_pair();

      @(posedge clk); #1;
      bus_b.d_i     = 8'h3C;
      bus_b.ps2_c_i = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      bus_b.ps2_c_i = 1'b1;
      t0 = cyc;
      p0 = pulses_b;
      while (cyc < t0 + int'(TO_B) + 3) begin
         @(posedge clk); #1;
      end
      bus_b.frame_i = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
      end
      bus_b.frame_i = 1'b0;
      repeat (30) @(posedge clk);
      @(negedge clk);
      check("collide_pulses", pulses_b - p0, 1);
      check("collide_q", int'(bus_b.q_o), 8'h3C);

      tog_en = 1'b1;
      for (int i = 0; i < 3; i++) frame_op(8'($urandom), 1'b0, 1'b0, 0);
      @(posedge clk); #1;
      bus_a.d_i     = 8'h77;
      bus_a.frame_i = 1'b1;
      @(posedge clk); #1;
      check("midrst_in_clear", int'(bus_a.shf_reset_o), 1);
      #2 rst = 1'b1;
      #1;
      check("midrst_valid", int'(bus_a.valid_o), 0);
      check("midrst_shf", int'(bus_a.shf_reset_o), 0);
      check("midrst_q", int'(bus_a.q_o), 0);
      bus_a.frame_i = 1'b0;
      ovf_exp = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      frame_op(8'h12, 1'b0, 1'b0, 0);
      @(negedge clk);
      check("midrst_new_q", int'(bus_a.q_o), 8'h12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/uxa_ps2_rxq.md
# uxa_ps2_rxq

Receive controller sitting directly downstream of the PS/2 deserializing shift register in the UXA keyboard/mouse port. It watches the shifter's frame indication, captures each completed byte into a small first-word-fall-through FIFO, and pulses the shifter's reset to re-arm it for the next frame. It also resets the shifter after a stalled partial frame, i.e. when the PS/2 clock has been quiet too long, so a glitch cannot desynchronise the port. The CPU-side register interface pops bytes from the FIFO.

## Interface
- DEPTH, 16: FIFO depth in bytes; power of two, 2..256.
- TIMEOUT, 25000: sys_clk_i cycles of PS/2 clock inactivity before a resync reset (2 ms at 12.5 MHz).
- sys_clk_i  in  1  system clock; the only clock.
- reset_i  in  1  reset, asynchronous, active-high.
- d_i  in  8  byte from the shifter's d_o.
- frame_i  in  1  shifter's frame_o; high while a complete, aligned frame sits in the shifter.
- ps2_c_i  in  1  raw PS/2 clock line, asynchronous.
- shf_reset_o  out  1  re-arm pulse to the shifter; the top level ORs it with reset_i.
- q_o  out  8  head-of-FIFO byte; 8'h00 when empty.
- valid_o  out  1  FIFO not empty.
- read_i  in  1  pop the head byte; ignored when valid_o=0.
- full_o  out  1  FIFO holds DEPTH bytes.
- overflow_o  out  1  sticky: a frame was dropped because the FIFO was full.
- clr_ovf_i  in  1  clears overflow_o.

## Operation
- Capture FSM states:
  - IDLE. If frame_i=1: push d_i (or drop it and set overflow_o when the FIFO is full and read_i=0), then go to CLEAR.
  - CLEAR. shf_reset_o=1 for exactly this one cycle, then go to WAIT_LOW.
  - WAIT_LOW. Stay until frame_i=0, then go to IDLE. frame_i is not sampled for capture here, so a byte is never captured twice.
- Activity watchdog:
  - ps2_c_i passes through a 2-flop synchroniser. Any edge of the synchronised signal, rising or falling, clears the counter to 0.
  - Otherwise the counter increments and saturates at TIMEOUT.
  - The counter has ceil(log2(TIMEOUT+1)) bits.
  - On the cycle the counter first reaches TIMEOUT and the FSM is in IDLE with frame_i=0, shf_reset_o pulses for 1 cycle. This fires at most once per quiet period; an edge re-arms it.
- Watchdog vs. frame in the same cycle: the frame wins and the capture path issues the only pulse. The watchdog is then re-armed only by a later edge.
- FIFO:
  - Write pointer, read pointer, and a count of width log2(DEPTH)+1.
  - full_o = (count==DEPTH); valid_o = (count!=0).
  - q_o = mem[rd_ptr] when valid_o, else 8'h00.
  - Pointers wrap modulo DEPTH.
- Push and pop in the same cycle:
  - Both take effect and count is unchanged.
  - When full, the simultaneous pop frees the slot, so the push is accepted and overflow_o is not set.
  - When empty, only the push occurs, since read_i is ignored.
- overflow_o: set has priority over clr_ovf_i in the same cycle.
- Reset (any time, including mid-frame or in CLEAR/WAIT_LOW):
  - FSM goes to IDLE, pointers and count to 0, watchdog counter to 0, synchroniser flops to 1.
  - Outputs: shf_reset_o=0, valid_o=0, full_o=0, overflow_o=0, q_o=8'h00.
  - FIFO memory contents need not be cleared.

## Timing
- Everything is on sys_clk_i rising edges except the async reset.
- Capture latency: with frame_i=1 sampled in IDLE at edge N:
  - valid_o=1, the new count, and shf_reset_o=1 all appear after edge N.
  - shf_reset_o drops after edge N+1.
  - If the FIFO was non-empty, q_o is unchanged.
- Pop: read_i=1 at edge N updates q_o/valid_o after edge N.
- Watchdog latency: the pulse follows TIMEOUT cycles after the synchronised edge, plus 2 synchroniser cycles from the raw edge.
- Minimum spacing between captures is 3 cycles (IDLE, CLEAR, WAIT_LOW with frame_i already low). A real PS/2 frame period is about 1 ms, far longer.

## Test plan
- Reset: hold reset_i with all inputs toggling. Required: shf_reset_o=0, valid_o=0, full_o=0, overflow_o=0, q_o=8'h00. Release, then idle 10 cycles: outputs unchanged.
- Single byte: drive d_i=8'h64 and frame_i=1 until shf_reset_o is seen, then drop frame_i. Required: shf_reset_o high exactly 1 cycle, valid_o=1, q_o=8'h64. Then 1 cycle of read_i: valid_o=0, q_o=8'h00.
- Fill and overflow:
  - 16 frames with d_i = 8'h00..8'h0F and no reads: full_o=1 after the 16th, q_o=8'h00.
  - 17th frame, d_i=8'hAA: overflow_o=1 and the data is unchanged.
  - clr_ovf_i: overflow_o=0.
  - 16 reads return 8'h00..8'h0F in order.
- Full with simultaneous pop: with the FIFO full, frame 8'h55 captured on the same edge as read_i=1. Required: overflow_o=0, full_o stays 1, q_o advances by one, and 8'h55 is read out last.
- Watchdog:
  - One ps2_c_i low/high pair, then high for TIMEOUT+50 cycles: exactly one shf_reset_o pulse, at TIMEOUT+2 (±1) cycles after the rising edge.
  - Another edge re-arms it and a second pulse follows.
  - With TIMEOUT=8, check the frame_i=1 collision case: only one pulse.
- Reset mid-operation: after 3 pushes, assert reset_i while in CLEAR. Required: valid_o=0 and shf_reset_o=0 immediately (asynchronously). After release, a new frame 8'h12 gives q_o=8'h12.
